// File: rtl/mem_access_unit.sv
// MEM-stage access engine: scalar loads/stores as one 32-bit beat, matrix accesses as four.
// Define MEM_MATRIX_EN to build the 128-bit matrix path; without it every access is scalar.
module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       me_alu_o,
   input  logic [31:0]       me_regs_data2,
   input  logic [127:0]      me_matrix_o,
   input  logic              me_mem_read,
   input  logic              me_mem_write,
   input  logic [1:0]        me_w_select,
   input  logic [2:0]        me_func3_code,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_wstrb,
   input  logic              dmem_ready,
   input  logic [31:0]       dmem_rdata,
   output logic              stall,
   output logic [31:0]       mem_rdata_o,
   output logic [127:0]      mem_matrix_rdata_o,
   output logic              done
);

`ifdef MEM_MATRIX_EN
   localparam int BEAT_W = 2;
`else
   localparam int BEAT_W = 1;
`endif

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       sdata_q;
   logic [2:0]        f3_q;
   logic              we_q;
   logic [31:0]       rdata_q, rdata_d;
   logic              latch_en, beat_ok, last_beat, ld_scalar;
   logic [31:0]       scal_wdata, beat_wdata;
   logic [3:0]        scal_wstrb, beat_wstrb;
   logic [7:0]        ld_b;
   logic [15:0]       ld_h;

   assign beat_ok = (state_q == S_BUSY) && dmem_ready;

`ifdef MEM_MATRIX_EN
   logic             mat_q;
   logic [3:0][31:0] mdata_q;
   logic [2:0][31:0] rbuf_q;
   logic [3:0][31:0] mrdata_q;

   assign last_beat          = !mat_q || (beat_q == 2'd3);
   assign ld_scalar          = !mat_q;
   assign beat_wdata         = mat_q ? mdata_q[beat_q] : scal_wdata;
   assign beat_wstrb         = !we_q ? 4'h0 : (mat_q ? 4'hF : scal_wstrb);
   assign mem_matrix_rdata_o = mrdata_q;

   // Beats 0..2 park in rbuf; the visible result only changes once all four words are in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mat_q    <= 1'b0;
         mdata_q  <= '0;
         rbuf_q   <= '0;
         mrdata_q <= '0;
      end else begin
         if (latch_en) begin
            mat_q   <= (me_w_select == 2'b10);
            mdata_q <= me_matrix_o;
         end
         if (beat_ok && !we_q && mat_q) begin
            if (beat_q == 2'd3) mrdata_q <= {dmem_rdata, rbuf_q};
            else                rbuf_q[beat_q] <= dmem_rdata;
         end
      end
   end
`else
   logic unused_mat;
   assign unused_mat         = ^{me_w_select, me_matrix_o};
   assign last_beat          = 1'b1;
   assign ld_scalar          = 1'b1;
   assign beat_wdata         = scal_wdata;
   assign beat_wstrb         = we_q ? scal_wstrb : 4'h0;
   assign mem_matrix_rdata_o = '0;
`endif

   always_comb begin
      scal_wdata = sdata_q;
      scal_wstrb = 4'h0;
      case (f3_q)
         3'b000: begin
            scal_wdata = {4{sdata_q[7:0]}};
            scal_wstrb = 4'b0001 << addr_q[1:0];
         end
         3'b001: begin
            scal_wdata = {2{sdata_q[15:0]}};
            scal_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
         end
         3'b010:  scal_wstrb = 4'hF;
         default: scal_wstrb = 4'h0;
      endcase
   end

   assign ld_b = 8'(dmem_rdata >> {addr_q[1:0], 3'b000});
   assign ld_h = 16'(dmem_rdata >> {addr_q[1], 4'b0000});

   always_comb begin
      rdata_d = '0;
      case (f3_q)
         3'b000:  rdata_d = {{24{ld_b[7]}}, ld_b};
         3'b100:  rdata_d = {24'h0, ld_b};
         3'b001:  rdata_d = {{16{ld_h[15]}}, ld_h};
         3'b101:  rdata_d = {16'h0, ld_h};
         3'b010:  rdata_d = dmem_rdata;
         default: rdata_d = '0;
      endcase
   end

   // stall is gated by rst so a held request cannot stall the pipe while in reset.
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      latch_en   = 1'b0;
      stall      = 1'b0;
      done       = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      dmem_wstrb = '0;
      case (state_q)
         S_IDLE: begin
            if (me_mem_read | me_mem_write) begin
               stall    = rst;
               latch_en = 1'b1;
               beat_d   = '0;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            stall      = 1'b1;
            dmem_req   = 1'b1;
            dmem_we    = we_q;
            dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'({beat_q, 2'b00});
            dmem_wdata = beat_wdata;
            dmem_wstrb = beat_wstrb;
            if (dmem_ready) begin
               beat_d = beat_q + 1'b1;
               if (last_beat) begin
                  beat_d  = '0;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         sdata_q <= '0;
         f3_q    <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (latch_en) begin
            addr_q  <= me_alu_o[ADDR_W-1:0];
            sdata_q <= me_regs_data2;
            f3_q    <= me_func3_code;
            we_q    <= me_mem_write;
         end
         if (beat_ok && !we_q && ld_scalar && last_beat) rdata_q <= rdata_d;
      end
   end

   assign mem_rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: scalar/matrix access, wait states, back-to-back, reset abort.
module tb_mem_access_unit;
   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  me_alu_o, me_regs_data2;
   logic [127:0] me_matrix_o;
   logic         me_mem_read, me_mem_write;
   logic [1:0]   me_w_select;
   logic [2:0]   me_func3_code;
   logic         dmem_req, dmem_we, dmem_ready;
   logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]   dmem_wstrb;
   logic         stall, done;
   logic [31:0]  mem_rdata_o;
   logic [127:0] mem_matrix_rdata_o;

   int checks = 0;
   int errors = 0;

   // Observations gathered by issue(): b_* per accepted beat, c_* per BUSY cycle.
   logic [31:0] b_addr [8];
   logic [31:0] b_wdata[8];
   logic [3:0]  b_wstrb[8];
   logic        b_we   [8];
   logic [31:0] c_addr [16];
   logic [31:0] c_wdata[16];
   logic [3:0]  c_wstrb[16];
   int          nb, nc, n_cyc, n_stall;
   logic        first_stall, timed_out;

   mem_access_unit #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2), .me_matrix_o(me_matrix_o),
      .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
      .me_w_select(me_w_select), .me_func3_code(me_func3_code),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .stall(stall), .mem_rdata_o(mem_rdata_o),
      .mem_matrix_rdata_o(mem_matrix_rdata_o), .done(done)
   );

   always #5 clk = ~clk;

   // Presents one op, scrambles me_* while BUSY, serves beat words from rw and
   // holds ready low wn times on beat wbeat; returns once done is seen.
   task automatic issue(input logic rd, input logic wr, input logic [1:0] wsel,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d2,
                        input logic [127:0] md, input logic [127:0] rw,
                        input int wbeat, input int wn);
      int waited;
      waited = 0; nb = 0; nc = 0; n_cyc = 0; n_stall = 0; timed_out = 1'b1; first_stall = 1'b0;
      @(posedge clk); #1;
      me_mem_read = rd; me_mem_write = wr; me_w_select = wsel; me_func3_code = f3;
      me_alu_o = addr; me_regs_data2 = d2; me_matrix_o = md;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (cyc == 0) first_stall = stall;
         n_cyc++;
         if (stall) n_stall++;
         if (done) begin
            timed_out = 1'b0;
            me_mem_read = 1'b0; me_mem_write = 1'b0;
            break;
         end
         if (dmem_req) begin
            if (nc < 16) begin
               c_addr[nc] = dmem_addr; c_wdata[nc] = dmem_wdata; c_wstrb[nc] = dmem_wstrb;
               nc++;
            end
            dmem_rdata = (nb < 4) ? rw[nb*32 +: 32] : 32'h0;
            if (nb == wbeat && waited < wn) begin
               dmem_ready = 1'b0;
               waited++;
            end else begin
               dmem_ready = 1'b1;
               if (nb < 8) begin
                  b_addr[nb] = dmem_addr; b_wdata[nb] = dmem_wdata;
                  b_wstrb[nb] = dmem_wstrb; b_we[nb] = dmem_we;
               end
               nb++;
            end
            me_alu_o = ~addr; me_regs_data2 = ~d2; me_matrix_o = ~md;
            me_func3_code = ~f3; me_w_select = ~wsel;
         end
      end
      dmem_ready = 1'b1;
      if (timed_out) begin
         checks++; errors++;
         $display("FAIL issue_timeout: no done within 40 cycles (addr %h)", addr);
         me_mem_read = 1'b0; me_mem_write = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; dmem_ready = 1'b1; dmem_rdata = '0;
      me_mem_read = 1'b0; me_mem_write = 1'b0; me_w_select = '0; me_func3_code = '0;
      me_alu_o = '0; me_regs_data2 = '0; me_matrix_o = '0;
      repeat (2) @(negedge clk);
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", dmem_req); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
      checks++; if (dmem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", dmem_addr); end
      checks++; if (dmem_wstrb !== 4'h0) begin errors++; $display("FAIL rst_wstrb got %h want 0", dmem_wstrb); end
      checks++; if (mem_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", mem_rdata_o); end
      checks++; if (mem_matrix_rdata_o !== 128'h0) begin errors++; $display("FAIL rst_mrdata got %h want 0", mem_matrix_rdata_o); end
      me_mem_read = 1'b1; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
      me_mem_read = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b want 0", stall); end
   endtask

   task automatic test_lw;
      issue(1'b1, 1'b0, 2'b00, 3'b010, 32'h100, 32'h0, 128'h0, 128'h8765_4321, 0, 0);
      checks++; if (n_cyc !== 3) begin errors++; $display("FAIL lw_latency got %0d want 3", n_cyc); end
      checks++; if (n_stall !== 2) begin errors++; $display("FAIL lw_stall_cycles got %0d want 2", n_stall); end
      checks++; if (first_stall !== 1'b1) begin errors++; $display("FAIL lw_idle_stall got %b want 1", first_stall); end
      checks++; if (b_addr[0] !== 32'h100) begin errors++; $display("FAIL lw_addr got %h want 100", b_addr[0]); end
      checks++; if (b_we[0] !== 1'b0 || b_wstrb[0] !== 4'h0) begin errors++; $display("FAIL lw_we_wstrb got %b/%h want 0/0", b_we[0], b_wstrb[0]); end
      checks++; if (mem_rdata_o !== 32'h8765_4321) begin errors++; $display("FAIL lw_data got %h want 87654321", mem_rdata_o); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL lw_after_done got done=%b stall=%b want 0/0", done, stall); end
   endtask

   task automatic test_load_format;
      logic [2:0]  f3v [7];
      logic [31:0] av  [7];
      logic [31:0] ev  [7];
      f3v = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b011};
      av  = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h100};
      ev  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
              32'h0000_007F, 32'hFFFF_FF7F, 32'h0};
      for (int i = 0; i < 7; i++) begin
         issue(1'b1, 1'b0, 2'b00, f3v[i], av[i], 32'h0, 128'h0, 128'h80FF_FF7F, 0, 0);
         checks++;
         if (mem_rdata_o !== ev[i]) begin
            errors++; $display("FAIL load_fmt[%0d] f3=%b addr=%h got %h want %h", i, f3v[i], av[i], mem_rdata_o, ev[i]);
         end
      end
      checks++; if (nb !== 1 || n_cyc !== 3) begin errors++; $display("FAIL reserved_beat got beats=%0d cyc=%0d want 1/3", nb, n_cyc); end
   endtask

   task automatic test_store;
      logic [2:0]  f3v [4];
      logic [31:0] av [4], dv [4], ea [4], ed [4];
      logic [3:0]  es [4];
      f3v = '{3'b001, 3'b000, 3'b010, 3'b000};
      av  = '{32'h202, 32'h201, 32'h20F, 32'h203};
      dv  = '{32'h0000_BEEF, 32'h1234_56A5, 32'h1234_5678, 32'h0000_003C};
      ea  = '{32'h200, 32'h200, 32'h20C, 32'h200};
      es  = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
      ed  = '{32'hBEEF_BEEF, 32'hA5A5_A5A5, 32'h1234_5678, 32'h3C3C_3C3C};
      issue(1'b1, 1'b0, 2'b00, 3'b010, 32'h1F0, 32'h0, 128'h0, 128'h5A5A_1234, 0, 0);
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, 1'b1, 2'b00, f3v[i], av[i], dv[i], 128'h0, 128'h0, 0, 0);
         checks++;
         if (b_addr[0] !== ea[i] || b_wstrb[0] !== es[i] || b_wdata[0] !== ed[i] || b_we[0] !== 1'b1) begin
            errors++;
            $display("FAIL store[%0d] got addr=%h wstrb=%b wdata=%h we=%b want %h/%b/%h/1",
                     i, b_addr[0], b_wstrb[0], b_wdata[0], b_we[0], ea[i], es[i], ed[i]);
         end
      end
      checks++; if (mem_rdata_o !== 32'h5A5A_1234) begin errors++; $display("FAIL store_keeps_rdata got %h want 5a5a1234", mem_rdata_o); end
   endtask

   task automatic test_wait_states;
      issue(1'b0, 1'b1, 2'b00, 3'b010, 32'h10C, 32'hA1B2_C3D4, 128'h0, 128'h0, 0, 2);
      checks++; if (n_cyc !== 5 || nc !== 3) begin errors++; $display("FAIL wait_sw_latency got cyc=%0d busy=%0d want 5/3", n_cyc, nc); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (c_addr[i] !== 32'h10C || c_wdata[i] !== 32'hA1B2_C3D4 || c_wstrb[i] !== 4'hF) begin
            errors++; $display("FAIL wait_stable[%0d] got %h/%h/%h want 10c/a1b2c3d4/f", i, c_addr[i], c_wdata[i], c_wstrb[i]);
         end
      end
      issue(1'b1, 1'b0, 2'b00, 3'b010, 32'h104, 32'h0, 128'h0, 128'h0BAD_F00D, 0, 3);
      checks++; if (n_cyc !== 6) begin errors++; $display("FAIL wait_lw_latency got %0d want 6", n_cyc); end
      checks++; if (mem_rdata_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL wait_lw_data got %h want 0badf00d", mem_rdata_o); end
   endtask

   task automatic test_back_to_back;
      issue(1'b1, 1'b0, 2'b00, 3'b010, 32'h140, 32'h0, 128'h0, 128'h0102_0304, 0, 0);
      checks++; if (mem_rdata_o !== 32'h0102_0304) begin errors++; $display("FAIL b2b_first got %h want 01020304", mem_rdata_o); end
      issue(1'b1, 1'b0, 2'b00, 3'b001, 32'h142, 32'h0, 128'h0, 128'hABCD_0000, 0, 0);
      checks++; if (first_stall !== 1'b1 || n_cyc !== 3) begin errors++; $display("FAIL b2b_detect got stall=%b cyc=%0d want 1/3", first_stall, n_cyc); end
      checks++; if (mem_rdata_o !== 32'hFFFF_ABCD) begin errors++; $display("FAIL b2b_second got %h want ffffabcd", mem_rdata_o); end
   endtask

`ifdef MEM_MATRIX_EN
   task automatic test_matrix;
      logic [127:0] md, rw;
      md = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
      rw = 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001;
      issue(1'b0, 1'b1, 2'b10, 3'b010, 32'h400, 32'h0, md, 128'h0, 0, 0);
      checks++; if (n_cyc !== 6 || n_stall !== 5 || nb !== 4) begin errors++; $display("FAIL mst_timing got cyc=%0d stall=%0d beats=%0d want 6/5/4", n_cyc, n_stall, nb); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (b_addr[k] !== 32'h400 + 32'(4*k) || b_wdata[k] !== md[k*32 +: 32] || b_wstrb[k] !== 4'hF) begin
            errors++; $display("FAIL mst_beat[%0d] got %h/%h/%h", k, b_addr[k], b_wdata[k], b_wstrb[k]);
         end
      end
      issue(1'b1, 1'b0, 2'b10, 3'b010, 32'h400, 32'h0, 128'h0, rw, 1, 2);
      checks++; if (n_cyc !== 8) begin errors++; $display("FAIL mld_latency got %0d want 8", n_cyc); end
      checks++;
      if (c_addr[1] !== 32'h404 || c_addr[2] !== 32'h404 || c_addr[3] !== 32'h404 || c_addr[5] !== 32'h40C) begin
         errors++; $display("FAIL mld_addr_hold got %h %h %h %h", c_addr[1], c_addr[2], c_addr[3], c_addr[5]);
      end
      checks++; if (mem_matrix_rdata_o !== rw) begin errors++; $display("FAIL mld_data got %h want %h", mem_matrix_rdata_o, rw); end
      checks++; if (mem_rdata_o !== 32'hFFFF_ABCD) begin errors++; $display("FAIL mld_keeps_rdata got %h want ffffabcd", mem_rdata_o); end
   endtask
`else
   task automatic test_matrix;
      issue(1'b1, 1'b0, 2'b10, 3'b010, 32'h100, 32'h0, 128'h0, 128'h1111_2222, 0, 0);
      checks++; if (n_cyc !== 3 || nb !== 1) begin errors++; $display("FAIL nomat_scalar got cyc=%0d beats=%0d want 3/1", n_cyc, nb); end
      checks++; if (mem_rdata_o !== 32'h1111_2222) begin errors++; $display("FAIL nomat_data got %h want 11112222", mem_rdata_o); end
      checks++; if (mem_matrix_rdata_o !== 128'h0) begin errors++; $display("FAIL nomat_mrdata got %h want 0", mem_matrix_rdata_o); end
   endtask
`endif

   task automatic test_reset_mid;
      logic [31:0]  exp_addr;
      logic [127:0] rw;
      int           nwait;
      rw = 128'h9999_0004_8888_0003_7777_0002_6666_0001;
`ifdef MEM_MATRIX_EN
      exp_addr = 32'h508; nwait = 4;
      @(posedge clk); #1;
      me_w_select = 2'b10; dmem_ready = 1'b1;
`else
      exp_addr = 32'h500; nwait = 3;
      @(posedge clk); #1;
      me_w_select = 2'b00; dmem_ready = 1'b0;
`endif
      me_mem_read = 1'b1; me_mem_write = 1'b0; me_func3_code = 3'b010; me_alu_o = 32'h500;
      repeat (nwait) @(negedge clk);
      checks++; if (dmem_req !== 1'b1 || dmem_addr !== exp_addr) begin errors++; $display("FAIL rmid_pre got req=%b addr=%h want 1/%h", dmem_req, dmem_addr, exp_addr); end
      #2 rst = 1'b0;
      #1;
      checks++; if (dmem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_drop got req=%b stall=%b done=%b want 0/0/0", dmem_req, stall, done); end
      checks++; if (mem_rdata_o !== 32'h0 || mem_matrix_rdata_o !== 128'h0) begin errors++; $display("FAIL rmid_clear got %h/%h want 0/0", mem_rdata_o, mem_matrix_rdata_o); end
      @(negedge clk);
      me_mem_read = 1'b0; dmem_ready = 1'b1; rst = 1'b1;
      issue(1'b1, 1'b0, me_w_select, 3'b010, 32'h500, 32'h0, 128'h0, rw, 0, 0);
      checks++; if (b_addr[0] !== 32'h500) begin errors++; $display("FAIL rmid_restart got %h want 500", b_addr[0]); end
`ifdef MEM_MATRIX_EN
      checks++; if (nb !== 4 || mem_matrix_rdata_o !== rw) begin errors++; $display("FAIL rmid_redo got beats=%0d data=%h want 4/%h", nb, mem_matrix_rdata_o, rw); end
`else
      checks++; if (nb !== 1 || mem_rdata_o !== 32'h6666_0001) begin errors++; $display("FAIL rmid_redo got beats=%0d data=%h want 1/66660001", nb, mem_rdata_o); end
`endif
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_format();
      test_store();
      test_wait_states();
      test_back_to_back();
      test_matrix();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access engine that consumes the EX/MEM pipeline register outputs and drives the 32-bit data-memory request/ready bus. Scalar loads/stores (byte/half/word per `me_func3_code`) take one bus beat; 128-bit matrix loads/stores take four sequential word beats. `stall` freezes the upstream pipeline until the access completes. Load results are formatted for the MEM/WB register.

## Interface
- `ADDR_W`, 32: data-memory address width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `me_alu_o`  in  32  effective address.
- `me_regs_data2`  in  32  scalar store data.
- `me_matrix_o`  in  128  matrix store data.
- `me_mem_read`, `me_mem_write`  in  1  access request; both high is treated as a write.
- `me_w_select`  in  2  `2'b10` selects a matrix access; other values select scalar.
- `me_func3_code`  in  3  scalar width/sign.
- `dmem_req`  out  1  bus request, held until `dmem_ready`.
- `dmem_we`  out  1  write enable.
- `dmem_addr`  out  ADDR_W  word-aligned beat address.
- `dmem_wdata`  out  32  write data, lane-aligned.
- `dmem_wstrb`  out  4  byte strobes; 0 on reads.
- `dmem_ready`  in  1  beat accepted/completed; `dmem_rdata` valid in the same cycle.
- `dmem_rdata`  in  32  read data.
- `stall`  out  1  hold the IF to EX/MEM stages.
- `mem_rdata_o`  out  32  formatted scalar load result.
- `mem_matrix_rdata_o`  out  128  assembled matrix load result.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM has three states: IDLE, BUSY and DONE. Reset puts the FSM in IDLE with `beat=0`. All outputs reset to 0.
- **IDLE**
  - An access is pending when `me_mem_read|me_mem_write` is high.
  - When pending: `stall=1` combinationally and the FSM moves to BUSY. Address, data, op, func3 and matrix flag are latched.
  - When not pending: `stall=0`.
- **BUSY**
  - Outputs: `dmem_req=1`, `stall=1`, `dmem_addr={addr[31:2],2'b00}+4*beat`.
  - On `dmem_ready`: capture read data into word `beat` and increment `beat`.
  - After the last beat (beat 0 for scalar, beat 3 for matrix), move to DONE.
- **DONE**
  - Outputs: `stall=0`, `done=1`, and the load results are updated.
  - The FSM returns to IDLE unconditionally. Because the pipeline advances this cycle, the same op is not re-serviced.
- **Scalar store lanes**
  - SB: `wstrb=1<<addr[1:0]`, with the byte replicated across all lanes.
  - SH: `wstrb=addr[1]?4'b1100:4'b0011`, with the half replicated. `addr[0]` is ignored.
  - SW: `wstrb=4'hF`. `addr[1:0]` is ignored.
- **Scalar load formatting**
  - LB/LBU: select the byte `addr[1:0]`, then sign-extend (LB) or zero-extend (LBU).
  - LH/LHU: select the half `addr[1]`, then sign-extend (LH) or zero-extend (LHU).
  - LW: pass the word through.
  - Reserved func3 values give a result of 0 but still perform the bus beat.
- **Matrix access**
  - Beat k transfers `me_matrix_o[32k+31:32k]` on a write, or fills `mem_matrix_rdata_o[32k+31:32k]` on a read.
  - Writes use `wstrb=4'hF`.
  - `mem_rdata_o` is not modified.
- `mem_rdata_o` and `mem_matrix_rdata_o` hold their values until the next load completes.

## Timing
- Scalar access with `dmem_ready` tied high:
  - cycle 0: IDLE, `stall=1`.
  - cycle 1: BUSY, beat.
  - cycle 2: DONE.
  - Latency is 3 cycles.
- Matrix access with `dmem_ready` tied high: 6 cycles (IDLE, 4×BUSY, DONE).
- Each wait-state cycle with `dmem_ready=0` adds one cycle. During wait states `dmem_addr`, `dmem_wdata` and `dmem_wstrb` stay stable.
- Back-to-back accesses: the next op is detected in the cycle immediately after DONE.
- Asserting `rst` low mid-access immediately drops `dmem_req`, `stall` and `done`. It also aborts the beat sequence, and partially filled read data is discarded (cleared).
- Latched inputs are used during BUSY. Changes on `me_*` while stalled are ignored.

## Configuration
- `MEM_MATRIX_EN`
  - Defined: the matrix path is present as described above.
  - Undefined: `me_w_select` is ignored and every access is scalar. `mem_matrix_rdata_o` is tied to 0, the beat counter is 1 bit and matrix latches are removed.

## Test plan
- LW at address 0x100, rdata 0x8765_4321, ready tied high -> `mem_rdata_o=0x87654321`. `stall` high for exactly 2 cycles, `done` pulses in cycle 2.
- LB at 0x103 and then LBU at 0x103, rdata 0x80FF_FF7F -> results 0xFFFF_FF80 and 0x0000_0080.
- SH at 0x202, data 0x0000_BEEF -> `dmem_addr=0x200`, `wstrb=4'b1100`, `wdata=0xBEEF_BEEF`, `dmem_we=1`.
- Matrix store at 0x400 with `me_matrix_o=0x44..33..22..11` (one word each) -> beats to addresses 0x400, 0x404, 0x408, 0x40C with data 0x11.., 0x22.., 0x33.., 0x44.. in that order. `stall` high for 5 cycles.
- Matrix load with 2 wait states on beat 1 -> the address holds 0x404 for 3 cycles and `mem_matrix_rdata_o` assembles correctly. Total latency is 8 cycles.
- `rst` pulsed low during matrix beat 2 -> `dmem_req=0` in the same cycle, FSM in IDLE, outputs 0. After release, the pending op restarts from beat 0.
